// File: rtl/regression_accumulator_if.sv
// Bundle between the regression accumulator and its environment: the start
// request, the loader's sample pair, the sample index and the held sums.
interface regression_accumulator_if #(
  parameter int DW    = 20,
  parameter int CNT_W = 8
);
  logic                    start;
  logic [DW-1:0]           x;
  logic [DW-1:0]           y;
  logic [CNT_W-1:0]        cnt;
  logic                    busy;
  logic                    done;
  logic [DW+CNT_W-1:0]     sum_x;
  logic [DW+CNT_W-1:0]     sum_y;
  logic [2*DW+CNT_W-1:0]   sum_xy;
  logic [2*DW+CNT_W-1:0]   sum_xx;

  // Accumulator side: takes start and samples, returns index, status and sums.
  modport slave (
    input  start, x, y,
    output cnt, busy, done, sum_x, sum_y, sum_xy, sum_xx
  );

  // Environment side: loader, coefficient stage and sequencer.
  modport master (
    output start, x, y,
    input  cnt, busy, done, sum_x, sum_y, sum_xy, sum_xx
  );
endinterface

// File: rtl/regression_accumulator.sv
// Sweeps N samples from the dataset loader once per start and accumulates
// sum_x, sum_y, sum_xy and sum_xx at full precision. Samples are captured into
// a one-deep pipeline register and accumulated on the following edge, so a
// DRAIN state retires the last sample before DONE is raised.
module regression_accumulator #(
  parameter int N     = 150,
  parameter int CNT_W = 8,
  parameter int DW    = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  regression_accumulator_if.slave   bus
);

  localparam int SW = DW + CNT_W;
  localparam int PW = 2 * DW + CNT_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_clear;
  logic              w_capture;
  logic              w_advance;
  logic              w_drain;

  logic [CNT_W-1:0]  r_cnt;
  logic [DW-1:0]     r_px;
  logic [DW-1:0]     r_py;
  logic              r_pipe_valid;
  logic              r_busy;
  logic              r_done;
  logic [SW-1:0]     r_sum_x;
  logic [SW-1:0]     r_sum_y;
  logic [PW-1:0]     r_sum_xy;
  logic [PW-1:0]     r_sum_xx;

  logic [2*DW-1:0]   w_pxy;
  logic [2*DW-1:0]   w_pxx;
  logic [SW-1:0]     w_px_ext;
  logic [SW-1:0]     w_py_ext;
  logic [PW-1:0]     w_pxy_ext;
  logic [PW-1:0]     w_pxx_ext;

  // Full-width products of the pipelined sample, zero-extended to the sums.
  assign w_pxy     = {{DW{1'b0}}, r_px} * {{DW{1'b0}}, r_py};
  assign w_pxx     = {{DW{1'b0}}, r_px} * {{DW{1'b0}}, r_px};
  assign w_px_ext  = {{CNT_W{1'b0}}, r_px};
  assign w_py_ext  = {{CNT_W{1'b0}}, r_py};
  assign w_pxy_ext = {{CNT_W{1'b0}}, w_pxy};
  assign w_pxx_ext = {{CNT_W{1'b0}}, w_pxx};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    w_drain     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_clear     = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_RUN: begin
        w_capture = 1'b1;
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_advance   = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        w_drain     = 1'b1;
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sample index: restarts at zero on a new sweep, holds at N-1 afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_clear) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_advance) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Pipeline register holding the sample fetched at the current index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_px         <= {DW{1'b0}};
      r_py         <= {DW{1'b0}};
      r_pipe_valid <= 1'b0;
    end else if (w_capture) begin
      r_px         <= bus.x;
      r_py         <= bus.y;
      r_pipe_valid <= 1'b1;
    end else if (w_clear || w_drain) begin
      r_pipe_valid <= 1'b0;
    end else begin
      r_pipe_valid <= r_pipe_valid;
    end
  end

  // Accumulators: cleared on a new sweep, add the pipelined sample when valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum_x  <= {SW{1'b0}};
      r_sum_y  <= {SW{1'b0}};
      r_sum_xy <= {PW{1'b0}};
      r_sum_xx <= {PW{1'b0}};
    end else if (w_clear) begin
      r_sum_x  <= {SW{1'b0}};
      r_sum_y  <= {SW{1'b0}};
      r_sum_xy <= {PW{1'b0}};
      r_sum_xx <= {PW{1'b0}};
    end else if (r_pipe_valid) begin
      r_sum_x  <= r_sum_x  + w_px_ext;
      r_sum_y  <= r_sum_y  + w_py_ext;
      r_sum_xy <= r_sum_xy + w_pxy_ext;
      r_sum_xx <= r_sum_xx + w_pxx_ext;
    end else begin
      r_sum_x  <= r_sum_x;
      r_sum_y  <= r_sum_y;
      r_sum_xy <= r_sum_xy;
      r_sum_xx <= r_sum_xx;
    end
  end

  // Registered status flags, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.cnt    = r_cnt;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.sum_x  = r_sum_x;
  assign bus.sum_y  = r_sum_y;
  assign bus.sum_xy = r_sum_xy;
  assign bus.sum_xx = r_sum_xx;

endmodule

// File: tb/tb_regression_accumulator.sv
// Directed and randomized checks of regression_accumulator against a loader
// memory and a plain-arithmetic reference of the four regression sums.
module tb_regression_accumulator;

  localparam int N     = 150;
  localparam int CNT_W = 8;
  localparam int DW    = 20;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  logic [DW-1:0] mem_x [0:255];
  logic [DW-1:0] mem_y [0:255];

  regression_accumulator_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

  regression_accumulator #(.N(N), .CNT_W(CNT_W), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Loader: combinational read of the sample index.
  assign bus.x = mem_x[bus.cnt];
  assign bus.y = mem_y[bus.cnt];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: kind 0=sum_x 1=sum_y 2=sum_xy 3=sum_xx over samples 0..N-1.
  function automatic logic [63:0] model_sum(input int kind);
    logic [63:0] acc;
    acc = 64'd0;
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       acc = acc + 64'(mem_x[i]);
        1:       acc = acc + 64'(mem_y[i]);
        2:       acc = acc + 64'(mem_x[i]) * 64'(mem_y[i]);
        default: acc = acc + 64'(mem_x[i]) * 64'(mem_x[i]);
      endcase
    end
    return acc;
  endfunction

  task automatic check_sums(input string pfx);
    check({pfx, "_sum_x"},  64'(bus.sum_x),  model_sum(0));
    check({pfx, "_sum_y"},  64'(bus.sum_y),  model_sum(1));
    check({pfx, "_sum_xy"}, 64'(bus.sum_xy), model_sum(2));
    check({pfx, "_sum_xx"}, 64'(bus.sum_xx), model_sum(3));
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      mem_x[i] = DW'($urandom);
      mem_y[i] = DW'($urandom);
    end
  endtask

  // One sweep: pulse start, then wait for done; optional extra start pulses.
  task automatic run_sweep(input string pfx, input int p1, input int p2);
    int lat;
    int seq_err;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({pfx, "_clr_done"}, 64'(bus.done), 64'd0);
    check({pfx, "_clr_sum_xy"}, 64'(bus.sum_xy), 64'd0);
    lat = 0;
    seq_err = 0;
    while (bus.done !== 1'b1 && lat < 1000) begin
      if (lat < N) begin
        if (bus.cnt !== CNT_W'(lat) || bus.busy !== 1'b1) seq_err++;
      end
      bus.start = (lat == p1) || (lat == p2);
      tick();
      bus.start = 1'b0;
      lat++;
    end
    check({pfx, "_latency"}, 64'(lat), 64'(N + 1));
    check({pfx, "_cnt_seq"}, 64'(seq_err), 64'd0);
    check({pfx, "_busy_done"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int highs;
    int dbl;
    logic prev;
    logic [63:0] ref_x;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem_x[i] = '0;
      mem_y[i] = '0;
    end
    repeat (3) tick();
    check("rst_cnt",  64'(bus.cnt),    64'd0);
    check("rst_busy", 64'(bus.busy),   64'd0);
    check("rst_done", 64'(bus.done),   64'd0);
    check("rst_sum",  64'(bus.sum_xx), 64'd0);
    rst = 1'b0;
    tick();

    // Constant samples x=1.0, y=2.0.
    for (int i = 0; i < 256; i++) begin
      mem_x[i] = 20'h00400;
      mem_y[i] = 20'h00800;
    end
    run_sweep("const", -1, -1);
    check("const_sum_x",  64'(bus.sum_x),  64'h25800);
    check("const_sum_y",  64'(bus.sum_y),  64'd300 << 10);
    check("const_sum_xx", 64'(bus.sum_xx), 64'd150 << 20);
    check("const_sum_xy", 64'(bus.sum_xy), 64'd300 << 20);

    // Ramp x=i.0, y=2i.0.
    for (int i = 0; i < 256; i++) begin
      mem_x[i] = DW'(i << 10);
      mem_y[i] = DW'((2 * i) << 10);
    end
    run_sweep("ramp", -1, -1);
    check("ramp_sum_x",  64'(bus.sum_x),  64'd11175 << 10);
    check("ramp_sum_y",  64'(bus.sum_y),  64'd22350 << 10);
    check("ramp_sum_xx", 64'(bus.sum_xx), 64'd1113775 << 20);
    check("ramp_sum_xy", 64'(bus.sum_xy), 64'd2227550 << 20);
    repeat (5) tick();
    check("ramp_hold_done", 64'(bus.done), 64'd1);
    check("ramp_hold_cnt",  64'(bus.cnt),  64'(N - 1));
    check_sums("ramp_hold");

    // Full-scale samples.
    for (int i = 0; i < 256; i++) begin
      mem_x[i] = 20'hFFFFF;
      mem_y[i] = 20'hFFFFF;
    end
    run_sweep("max", -1, -1);
    ref_x = 64'd150 * 64'hFFFFF;
    check("max_sum_x",  64'(bus.sum_x),  ref_x);
    check("max_sum_xx", 64'(bus.sum_xx), ref_x * 64'hFFFFF);

    // Random data with start pulses during the sweep.
    fill_random();
    run_sweep("pulse", 10, 80);
    check_sums("pulse");

    // Reset at sweep cycle 60.
    fill_random();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (60) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_cnt",  64'(bus.cnt),    64'd0);
    check("mid_rst_busy", 64'(bus.busy),   64'd0);
    check("mid_rst_done", 64'(bus.done),   64'd0);
    check("mid_rst_sx",   64'(bus.sum_x),  64'd0);
    check("mid_rst_sxy",  64'(bus.sum_xy), 64'd0);
    highs = 0;
    for (int c = 0; c < 200; c++) begin
      if (bus.done === 1'b1) highs++;
      tick();
    end
    check("mid_rst_no_done", 64'(highs), 64'd0);
    run_sweep("after_rst", -1, -1);
    check_sums("after_rst");

    // New loader contents from DONE.
    fill_random();
    run_sweep("redo", -1, -1);
    check_sums("redo");

    // Start held high: one done cycle per sweep.
    fill_random();
    bus.start = 1'b1;
    tick();
    highs = 0;
    dbl = 0;
    prev = 1'b0;
    for (int c = 0; c <= 3 * (N + 2) - 1; c++) begin
      if (bus.done === 1'b1) begin
        highs++;
        if (prev) dbl++;
        if (highs == 1) check_sums("held");
      end
      prev = bus.done;
      tick();
    end
    bus.start = 1'b0;
    check("held_done_count",  64'(highs), 64'd3);
    check("held_done_single", 64'(dbl),   64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
